fb_loader: RTL and testbench

Upstream write stage for the LED framebuffer. Accepts a byte stream from the host link (UART/SPI byte receiver), parses framed write packets, and writes pixel bytes into the back half of a double-buffered framebuffer RAM. The column/row shift driver reads the front half. On a validated packet with the swap flag set, the block swaps front/back at the driver's next frame boundary, so a partially written frame is never displayed.

---
 rtl/fb_loader.sv | 168 ++++++++++++++++
 tb/tb_fb_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_loader.sv
// Parses framed host write packets into the back framebuffer half; writes land one cycle after each payload byte.
// Backpressure: rx_ready drops only while a validated swap waits for the driver's frame boundary.
module fb_loader #(
  parameter int          FB_SIZE = 1728,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        frame_sync,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_en,
  output logic        buf_sel,
  output logic        frame_done,
  output logic [7:0]  err_count
);

  localparam logic [16:0] FB17 = 17'(FB_SIZE);
  localparam logic [15:0] FB16 = 16'(FB_SIZE);

  typedef enum logic [3:0] {
    S_IDLE, S_FLAGS, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA, S_CHK, S_SWAP_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic        swap_q, swap_d;
  logic [7:0]  chk_q, chk_d;
  logic [16:0] ptr_q, ptr_d;
  logic [15:0] len_q, len_d;
  logic        buf_sel_q, buf_sel_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  err_q, err_d;
  logic        accept;

  assign rx_ready   = (state_q != S_SWAP_WAIT);
  assign accept     = rx_valid && rx_ready;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_en      = wr_en_q;
  assign buf_sel    = buf_sel_q;
  assign frame_done = frame_done_q;
  assign err_count  = err_q;

  always_comb begin
    state_d      = state_q;
    swap_d       = swap_q;
    chk_d        = chk_q;
    ptr_d        = ptr_q;
    len_d        = len_q;
    buf_sel_d    = buf_sel_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept && rx_data == SYNC) begin
          chk_d   = 8'h00;
          state_d = S_FLAGS;
        end
      end
      S_FLAGS: begin
        if (accept) begin
          swap_d  = rx_data[0];
          chk_d   = rx_data;
          state_d = S_ADDR_H;
        end
      end
      S_ADDR_H: begin
        if (accept) begin
          ptr_d   = {1'b0, rx_data, 8'h00};
          chk_d   = chk_q ^ rx_data;
          state_d = S_ADDR_L;
        end
      end
      S_ADDR_L: begin
        if (accept) begin
          ptr_d   = {ptr_q[16:8], rx_data};
          chk_d   = chk_q ^ rx_data;
          state_d = S_LEN_H;
        end
      end
      S_LEN_H: begin
        if (accept) begin
          len_d   = {rx_data, 8'h00};
          chk_d   = chk_q ^ rx_data;
          state_d = S_LEN_L;
        end
      end
      S_LEN_L: begin
        if (accept) begin
          len_d   = {len_q[15:8], rx_data};
          chk_d   = chk_q ^ rx_data;
          state_d = ({len_q[15:8], rx_data} == 16'd0) ? S_CHK : S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          chk_d = chk_q ^ rx_data;
          // Out-of-range pixels are still consumed so the checksum covers the whole payload.
          if (ptr_q < FB17) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q[15:0] + (buf_sel_q ? 16'd0 : FB16);
            wr_data_d = rx_data;
          end
          ptr_d = ptr_q + 17'd1;
          len_d = len_q - 16'd1;
          if (len_q == 16'd1) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (rx_data == chk_q && swap_q) begin
            state_d = S_SWAP_WAIT;
          end else begin
            frame_done_d = 1'b1;
            if (rx_data != chk_q && err_q != 8'hFF) err_d = err_q + 8'd1;
            state_d = S_IDLE;
          end
        end
      end
      S_SWAP_WAIT: begin
        if (frame_sync) begin
          buf_sel_d    = ~buf_sel_q;
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      swap_q       <= 1'b0;
      chk_q        <= 8'h00;
      ptr_q        <= 17'd0;
      len_q        <= 16'd0;
      buf_sel_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 16'd0;
      wr_data_q    <= 8'h00;
      frame_done_q <= 1'b0;
      err_q        <= 8'h00;
    end else begin
      state_q      <= state_d;
      swap_q       <= swap_d;
      chk_q        <= chk_d;
      ptr_q        <= ptr_d;
      len_q        <= len_d;
      buf_sel_q    <= buf_sel_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_fb_loader.sv
// Directed plus randomized packets against a packet-level reference model of the loader.
module tb_fb_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        frame_sync;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        buf_sel;
  logic        frame_done;
  logic [7:0]  err_count;

  fb_loader dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_sync(frame_sync), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .buf_sel(buf_sel), .frame_done(frame_done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_wr   = 0;
  int fd_cnt = 0;

  // Reference model state
  logic [15:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  int          wr_cycles[$];
  logic [7:0]  pl[$];
  int          m_buf     = 0;
  int          m_err     = 0;
  int          m_fd      = 0;
  bit          m_pending = 0;
  bit          fs_on_last = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : monitor
    logic [15:0] ea;
    logic [7:0]  ed;
    if (rst === 1'b1) begin
      if (wr_en) begin
        n_wr++;
        wr_cycles.push_back(cyc);
        if (exp_addr.size() == 0) begin
          chk("unexpected_write", {16'd0, wr_addr}, 32'hFFFF_FFFF);
        end else begin
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          chk("wr_addr", {16'd0, wr_addr}, {16'd0, ea});
          chk("wr_data", {24'd0, wr_data}, {24'd0, ed});
        end
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic rand_pl(input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
  endtask

  // nsend < 0 sends the whole packet; wlim caps how many payload writes are expected.
  task automatic send_packet(input logic [7:0] flags, input logic [15:0] addr, input bit bad,
                             input int nsend, input int wlim);
    logic [7:0]  pk[$];
    logic [7:0]  c;
    logic [16:0] p;
    int          len = pl.size();
    int          n;
    c = flags ^ addr[15:8] ^ addr[7:0] ^ 8'(len >> 8) ^ 8'(len);
    pk.push_back(8'hA5);
    pk.push_back(flags);
    pk.push_back(addr[15:8]);
    pk.push_back(addr[7:0]);
    pk.push_back(8'(len >> 8));
    pk.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      pk.push_back(pl[i]);
      c = c ^ pl[i];
      p = {1'b0, addr} + 17'(i);
      if (p < 17'd1728 && i < wlim) begin
        exp_addr.push_back(16'(p + ((m_buf != 0) ? 17'd0 : 17'd1728)));
        exp_data.push_back(pl[i]);
      end
    end
    pk.push_back(bad ? (c ^ 8'(1 + $urandom_range(0, 254))) : c);
    n = (nsend < 0) ? pk.size() : nsend;
    for (int i = 0; i < n; i++) begin
      if (fs_on_last && i == pk.size() - 1) frame_sync = 1'b1;
      send_byte(pk[i]);
      frame_sync = 1'b0;
    end
    if (nsend < 0) begin
      if (bad) begin
        m_err = (m_err < 255) ? m_err + 1 : 255;
        m_fd++;
      end else if (flags[0]) begin
        m_pending = 1;
      end else begin
        m_fd++;
      end
    end
  endtask

  task automatic pulse_fs;
    bit had = m_pending;
    @(negedge clk);
    frame_sync = 1'b1;
    @(posedge clk);
    #1 frame_sync = 1'b0;
    if (had) begin
      m_buf     = 1 - m_buf;
      m_fd++;
      m_pending = 0;
    end
    chk("frame_done_on_swap", {31'd0, frame_done}, {31'd0, had});
    chk("buf_sel_after_sync", {31'd0, buf_sel}, 32'(m_buf));
    chk("rx_ready_after_sync", {31'd0, rx_ready}, 32'd1);
  endtask

  task automatic settle_and_check(input string tag);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_err"}, {24'd0, err_count}, 32'(m_err));
    chk({tag, "_buf"}, {31'd0, buf_sel}, 32'(m_buf));
    chk({tag, "_fd"}, 32'(fd_cnt), 32'(m_fd));
    chk({tag, "_wrq"}, 32'(exp_addr.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr0, fd0;
    logic [15:0] a;
    rst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; frame_sync = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_buf_sel", {31'd0, buf_sel}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {16'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_err", {24'd0, err_count}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic write with swap request
    pl = '{8'h11, 8'h22, 8'h33};
    wr_cycles.delete();
    send_packet(8'h01, 16'd0, 1'b0, -1, 1 << 30);
    chk("basic_no_fd_before_swap", {31'd0, frame_done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("basic_nwrites", 32'(wr_cycles.size()), 32'd3);
    if (wr_cycles.size() == 3) begin
      chk("basic_gap01", 32'(wr_cycles[1] - wr_cycles[0]), 32'd1);
      chk("basic_gap12", 32'(wr_cycles[2] - wr_cycles[1]), 32'd1);
    end
    chk("basic_rx_ready_wait", {31'd0, rx_ready}, 32'd0);
    chk("basic_buf_held", {31'd0, buf_sel}, 32'd0);
    pulse_fs();
    settle_and_check("basic");

    // frame_sync coincident with CHK acceptance is ignored
    rand_pl(2);
    fs_on_last = 1;
    send_packet(8'h01, 16'd5, 1'b0, -1, 1 << 30);
    fs_on_last = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("coinc_buf_held", {31'd0, buf_sel}, 32'(m_buf));
    chk("coinc_rx_ready", {31'd0, rx_ready}, 32'd0);
    pulse_fs();
    settle_and_check("coinc");

    // Bounds: only the first two pixels fit
    rand_pl(4);
    wr0 = n_wr;
    send_packet(8'h00, 16'd1726, 1'b0, -1, 1 << 30);
    settle_and_check("bounds");
    chk("bounds_nwrites", 32'(n_wr - wr0), 32'd2);

    // Bad checksum
    pl = '{8'h11, 8'h22, 8'h33};
    send_packet(8'h01, 16'd0, 1'b1, -1, 1 << 30);
    chk("bad_fd_pulse", {31'd0, frame_done}, 32'd1);
    chk("bad_rx_ready", {31'd0, rx_ready}, 32'd1);
    settle_and_check("bad");
    chk("bad_err_one", {24'd0, err_count}, 32'd1);

    // Framing: garbage then an empty packet
    wr0 = n_wr; fd0 = fd_cnt;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    pl.delete();
    send_packet(8'h00, 16'd0, 1'b0, -1, 1 << 30);
    settle_and_check("framing");
    chk("framing_nwrites", 32'(n_wr - wr0), 32'd0);
    chk("framing_fd_once", 32'(fd_cnt - fd0), 32'd1);

    // Randomized packets
    for (int k = 0; k < 10; k++) begin
      rand_pl($urandom_range(0, 8));
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                      : 16'($urandom_range(0, 1800));
      send_packet(8'($urandom), a, ($urandom_range(0, 3) == 0), -1, 1 << 30);
      if (m_pending) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1 chk("rand_wait_rx_ready", {31'd0, rx_ready}, 32'd0);
        pulse_fs();
      end
      settle_and_check("rand");
    end

    // Saturation
    pl.delete();
    for (int k = 0; k < 300; k++) send_packet(8'h00, 16'd0, 1'b1, -1, 1 << 30);
    settle_and_check("sat");
    chk("sat_255", {24'd0, err_count}, 32'd255);

    // Reset in DATA: second payload write is in flight when rst falls
    rand_pl(5);
    send_packet(8'h01, 16'd10, 1'b0, 8, 1);
    chk("mid_wr_en_high", {31'd0, wr_en}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_wr_en_drop", {31'd0, wr_en}, 32'd0);
    chk("mid_buf_sel", {31'd0, buf_sel}, 32'd0);
    chk("mid_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("mid_err", {24'd0, err_count}, 32'd0);
    m_buf = 0; m_err = 0; m_pending = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wr0 = n_wr;
    repeat (5) @(negedge clk);
    chk("mid_no_writes", 32'(n_wr - wr0), 32'd0);
    fd0 = fd_cnt; m_fd = fd_cnt;
    rand_pl(3);
    send_packet(8'h00, 16'd100, 1'b0, -1, 1 << 30);
    settle_and_check("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
